// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side, write-back and EX-side signal bundle for the ID/EX register.
// Signals:
//   id_*  decoded instruction fields, register-file data and control bits
//   wb_*  MEM/WB write port, used for the bypass on capture
//   ex_*  registered EX-stage instruction fields and control bits
// Modports: master drives id_*/wb_* and observes ex_*; slave is the pipeline register.
interface id_ex_stage_if #(parameter int DW = 32);
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_uses_rt;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst;
    logic [3:0]    id_aluop;
    logic          wb_regwrite;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          ex_valid;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst;
    logic [3:0]    ex_aluop;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst, id_aluop,
               wb_regwrite, wb_rd, wb_data,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst, ex_aluop
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
               id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst, id_aluop,
               wb_regwrite, wb_rd, wb_data,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst, ex_aluop
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion, flush and WB bypass.
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           taken branch/jump resolved in EX; turns the EX slot into a bubble
//   hold            global freeze; every register keeps its value
//   bus             id_ex_stage_if.slave: id_*/wb_* in, ex_* out
//   stall           combinational load-use stall to PC and IF/ID
//   stall_cnt       saturating count of stall bubbles inserted
//   flush_cnt       saturating count of flush cycles
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            hold,
    id_ex_stage_if.slave    bus,
    output logic            stall,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);
    logic          rs_hit, rt_hit, cap;
    logic [DW-1:0] rs_fwd, rt_fwd;

    always_comb begin
        rs_hit = bus.ex_rt == bus.id_rs;
        rt_hit = bus.id_uses_rt && bus.ex_rt == bus.id_rt;
        stall  = bus.ex_valid && bus.ex_memread && bus.ex_rt != 5'd0 && bus.id_valid
                 && (rs_hit || rt_hit) && !flush;
        // Controls survive only for a real instruction that is not being replaced by a bubble,
        // so a bubble can never look like a writer to the forwarding unit.
        cap    = bus.id_valid && !stall;
        // The register file is read in the same cycle WB writes it; take the value being written.
        rs_fwd = (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs) ? bus.wb_data : bus.id_rs_data;
        rt_fwd = (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rt) ? bus.wb_data : bus.id_rt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_rs       <= '0;
            bus.ex_rt       <= '0;
            bus.ex_rd       <= '0;
            bus.ex_rs_data  <= '0;
            bus.ex_rt_data  <= '0;
            bus.ex_imm      <= '0;
            bus.ex_regwrite <= 1'b0;
            bus.ex_memread  <= 1'b0;
            bus.ex_memwrite <= 1'b0;
            bus.ex_memtoreg <= 1'b0;
            bus.ex_alusrc   <= 1'b0;
            bus.ex_regdst   <= 1'b0;
            bus.ex_aluop    <= '0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else if (flush) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_rs       <= '0;
            bus.ex_rt       <= '0;
            bus.ex_rd       <= '0;
            bus.ex_rs_data  <= '0;
            bus.ex_rt_data  <= '0;
            bus.ex_imm      <= '0;
            bus.ex_regwrite <= 1'b0;
            bus.ex_memread  <= 1'b0;
            bus.ex_memwrite <= 1'b0;
            bus.ex_memtoreg <= 1'b0;
            bus.ex_alusrc   <= 1'b0;
            bus.ex_regdst   <= 1'b0;
            bus.ex_aluop    <= '0;
            flush_cnt       <= flush_cnt + {{(CNTW-1){1'b0}}, ~&flush_cnt};
        end else if (!hold) begin
            // Indices and data load even on a stall; they are don't-care inside a bubble.
            bus.ex_valid    <= cap;
            bus.ex_rs       <= bus.id_rs;
            bus.ex_rt       <= bus.id_rt;
            bus.ex_rd       <= bus.id_rd;
            bus.ex_rs_data  <= rs_fwd;
            bus.ex_rt_data  <= rt_fwd;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_regwrite <= cap && bus.id_regwrite;
            bus.ex_memread  <= cap && bus.id_memread;
            bus.ex_memwrite <= cap && bus.id_memwrite;
            bus.ex_memtoreg <= cap && bus.id_memtoreg;
            bus.ex_alusrc   <= cap && bus.id_alusrc;
            bus.ex_regdst   <= cap && bus.id_regdst;
            bus.ex_aluop    <= cap ? bus.id_aluop : 4'd0;
            stall_cnt       <= stall_cnt + {{(CNTW-1){1'b0}}, stall && ~&stall_cnt};
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven check of the ID/EX register plus reset and saturation sequences.
module tb_id_ex_stage;
    localparam int CNTW = 8;
    localparam int LW = 'b110110;
    localparam int RT = 'b100001;
    localparam int AI = 'b100010;

    typedef struct {
        logic v; logic [4:0] rs, rt, rd; logic ut;
        logic [31:0] rsd, rtd, imm; logic [5:0] ctrl; logic [3:0] op;
        logic wbw; logic [4:0] wbrd; logic [31:0] wbd; logic fl, hd;
    } in_t;

    typedef struct {
        logic st, v, cd; logic [4:0] rs, rt, rd;
        logic [31:0] rsd, rtd, imm; logic [5:0] ctrl; logic [3:0] op;
        logic [CNTW-1:0] sc, fc;
    } ex_t;

    typedef struct { in_t i; ex_t e; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush, hold, stall;
    logic [CNTW-1:0] stall_cnt, flush_cnt;
    int errors = 0;
    int checks = 0;
    vec_t tv[$];

    id_ex_stage_if #(.DW(32)) bus ();

    id_ex_stage #(.DW(32), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold), .bus(bus.slave),
        .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mi(input int v, rs, rt, rd, ut, input logic [31:0] rsd, rtd, imm,
                               input int ctrl, op, wbw, wbrd, input logic [31:0] wbd, input int fl, hd);
        in_t r;
        r.v = 1'(v); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.ut = 1'(ut);
        r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.ctrl = 6'(ctrl); r.op = 4'(op);
        r.wbw = 1'(wbw); r.wbrd = 5'(wbrd); r.wbd = wbd; r.fl = 1'(fl); r.hd = 1'(hd);
        return r;
    endfunction

    function automatic ex_t me(input int st, v, cd, rs, rt, rd, input logic [31:0] rsd, rtd, imm,
                               input int ctrl, op, sc, fc);
        ex_t r;
        r.st = 1'(st); r.v = 1'(v); r.cd = 1'(cd); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.ctrl = 6'(ctrl); r.op = 4'(op);
        r.sc = CNTW'(sc); r.fc = CNTW'(fc);
        return r;
    endfunction

    function automatic vec_t mv(input in_t i, input ex_t e);
        vec_t r;
        r.i = i; r.e = e;
        return r;
    endfunction

    task automatic drive(input in_t x);
        bus.id_valid = x.v; bus.id_rs = x.rs; bus.id_rt = x.rt; bus.id_rd = x.rd;
        bus.id_uses_rt = x.ut; bus.id_rs_data = x.rsd; bus.id_rt_data = x.rtd; bus.id_imm = x.imm;
        {bus.id_regwrite, bus.id_memread, bus.id_memwrite, bus.id_memtoreg, bus.id_alusrc, bus.id_regdst} = x.ctrl;
        bus.id_aluop = x.op; bus.wb_regwrite = x.wbw; bus.wb_rd = x.wbrd; bus.wb_data = x.wbd;
        flush = x.fl; hold = x.hd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] ex_ctrl();
        return {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_alusrc, bus.ex_regdst};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    in_t lw_i, add_i, add_h, add_f, idle;

    initial begin
        idle  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw_i  = mi(1, 1, 5, 0, 0, 32'h100, 0, 8, LW, 0, 0, 0, 0, 0, 0);
        add_i = mi(1, 5, 6, 7, 1, 3, 4, 0, RT, 2, 0, 0, 0, 0, 0);
        add_h = add_i; add_h.hd = 1'b1;
        add_f = add_i; add_f.fl = 1'b1;

        tv.push_back(mv(mi(1, 2, 3, 4, 1, 32'h11, 32'h22, 0, RT, 2, 0, 0, 0, 0, 0),
                        me(0, 1, 1, 2, 3, 4, 32'h11, 32'h22, 0, RT, 2, 0, 0)));
        tv.push_back(mv(lw_i, me(0, 1, 1, 1, 5, 0, 32'h100, 0, 8, LW, 0, 0, 0)));
        tv.push_back(mv(add_i, me(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        tv.push_back(mv(add_i, me(0, 1, 1, 5, 6, 7, 3, 4, 0, RT, 2, 1, 0)));
        tv.push_back(mv(lw_i, me(0, 1, 1, 1, 5, 0, 32'h100, 0, 8, LW, 0, 1, 0)));
        tv.push_back(mv(mi(1, 1, 5, 0, 0, 9, 9, 32'h20, AI, 2, 0, 0, 0, 0, 0),
                        me(0, 1, 1, 1, 5, 0, 9, 9, 32'h20, AI, 2, 1, 0)));
        tv.push_back(mv(mi(1, 2, 0, 0, 0, 7, 0, 4, LW, 0, 0, 0, 0, 0, 0),
                        me(0, 1, 1, 2, 0, 0, 7, 0, 4, LW, 0, 1, 0)));
        tv.push_back(mv(mi(1, 0, 0, 1, 1, 0, 0, 0, RT, 2, 0, 0, 0, 0, 0),
                        me(0, 1, 1, 0, 0, 1, 0, 0, 0, RT, 2, 1, 0)));
        tv.push_back(mv(mi(1, 7, 8, 9, 1, 0, 32'h55, 0, RT, 2, 1, 7, 32'hDEADBEEF, 0, 0),
                        me(0, 1, 1, 7, 8, 9, 32'hDEADBEEF, 32'h55, 0, RT, 2, 1, 0)));
        tv.push_back(mv(mi(1, 0, 0, 9, 1, 32'h12, 32'h34, 0, RT, 2, 1, 0, 32'hDEADBEEF, 0, 0),
                        me(0, 1, 1, 0, 0, 9, 32'h12, 32'h34, 0, RT, 2, 1, 0)));
        tv.push_back(mv(mi(1, 3, 7, 9, 1, 1, 0, 0, RT, 2, 1, 7, 32'hCAFEF00D, 0, 0),
                        me(0, 1, 1, 3, 7, 9, 1, 32'hCAFEF00D, 0, RT, 2, 1, 0)));
        tv.push_back(mv(mi(0, 4, 5, 6, 1, 32'hA, 32'hB, 32'hC, 'h3F, 'hF, 0, 0, 0, 0, 0),
                        me(0, 0, 1, 4, 5, 6, 32'hA, 32'hB, 32'hC, 0, 0, 1, 0)));
        tv.push_back(mv(lw_i, me(0, 1, 1, 1, 5, 0, 32'h100, 0, 8, LW, 0, 1, 0)));
        tv.push_back(mv(add_f, me(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)));
        tv.push_back(mv(lw_i, me(0, 1, 1, 1, 5, 0, 32'h100, 0, 8, LW, 0, 1, 1)));
        for (int k = 0; k < 3; k++)
            tv.push_back(mv(add_h, me(1, 1, 1, 1, 5, 0, 32'h100, 0, 8, LW, 0, 1, 1)));
        tv.push_back(mv(add_i, me(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1)));
        tv.push_back(mv(add_i, me(0, 1, 1, 5, 6, 7, 3, 4, 0, RT, 2, 2, 1)));

        drive(idle);
        #2;
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_ctrl", 32'(ex_ctrl()), 0);
        chk("rst_data", bus.ex_rs_data | bus.ex_rt_data | bus.ex_imm, 0);
        chk("rst_cnt", 32'({stall_cnt, flush_cnt}), 0);
        chk("rst_stall", 32'(stall), 0);
        step();
        rst_n = 1'b1;

        foreach (tv[n]) begin
            drive(tv[n].i);
            #1;
            chk($sformatf("v%0d_stall", n), 32'(stall), 32'(tv[n].e.st));
            step();
            chk($sformatf("v%0d_valid", n), 32'(bus.ex_valid), 32'(tv[n].e.v));
            chk($sformatf("v%0d_ctrl", n), 32'(ex_ctrl()), 32'(tv[n].e.ctrl));
            chk($sformatf("v%0d_aluop", n), 32'(bus.ex_aluop), 32'(tv[n].e.op));
            chk($sformatf("v%0d_stall_cnt", n), 32'(stall_cnt), 32'(tv[n].e.sc));
            chk($sformatf("v%0d_flush_cnt", n), 32'(flush_cnt), 32'(tv[n].e.fc));
            if (tv[n].e.cd) begin
                chk($sformatf("v%0d_idx", n), 32'({bus.ex_rs, bus.ex_rt, bus.ex_rd}),
                    32'({tv[n].e.rs, tv[n].e.rt, tv[n].e.rd}));
                chk($sformatf("v%0d_rs_data", n), bus.ex_rs_data, tv[n].e.rsd);
                chk($sformatf("v%0d_rt_data", n), bus.ex_rt_data, tv[n].e.rtd);
                chk($sformatf("v%0d_imm", n), bus.ex_imm, tv[n].e.imm);
            end
        end

        drive(lw_i);
        step();
        drive(add_i);
        #1;
        chk("pre_rst_stall", 32'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.ex_valid), 0);
        chk("async_ctrl", 32'(ex_ctrl()), 0);
        chk("async_idx", 32'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 0);
        chk("async_data", bus.ex_rs_data | bus.ex_imm, 0);
        chk("async_cnt", 32'({stall_cnt, flush_cnt}), 0);
        chk("async_stall", 32'(stall), 0);
        step();
        chk("held_valid", 32'(bus.ex_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", 32'(stall), 0);
        step();
        chk("post_rst_load", 32'({bus.ex_valid, bus.ex_rs, bus.ex_rt}), 32'({1'b1, 5'd5, 5'd6}));

        for (int k = 0; k < 300; k++) begin
            drive(lw_i);
            step();
            drive(add_i);
            step();
            if (k == 253) chk("stall_cnt_254", 32'(stall_cnt), 254);
        end
        chk("stall_sat", 32'(stall_cnt), 32'((1 << CNTW) - 1));
        drive(add_f);
        for (int k = 0; k < 300; k++) step();
        chk("flush_sat", 32'(flush_cnt), 32'((1 << CNTW) - 1));
        chk("stall_kept", 32'(stall_cnt), 32'((1 << CNTW) - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
